// File: rtl/warblade_pkg.sv
// Shared constants for the player 2 UART keyboard path: default key codes and
// the read-FSM state encoding.
package warblade_pkg;

   localparam logic [7:0] KEY_LEFT_DEF  = 8'h61;
   localparam logic [7:0] KEY_RIGHT_DEF = 8'h64;
   localparam logic [7:0] KEY_SHOOT_DEF = 8'h77;
   localparam logic [7:0] KEY_STOP_DEF  = 8'h73;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_POP    = 2'd1,
      S_SETTLE = 2'd2
   } state_t;

endpackage

// File: rtl/uart_key_hold_decoder_hold_timer.sv
// Reloadable down-counter; active is high exactly while the count is nonzero,
// registered so it falls on the same edge the count steps 1->0.
module hold_timer #(
   parameter int MAX = 1
) (
   input  logic pclk,
   input  logic rst,
   input  logic load,
   input  logic clear,
   output logic active
);

   localparam int W = $clog2(MAX + 1);

   logic [W-1:0] r_cnt;
   logic         r_active;

   // Load wins over clear and over the decrement; a zero count stays at zero.
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_active <= 1'b0;
      end else if (load) begin
         r_cnt    <= W'(MAX);
         r_active <= 1'b1;
      end else if (clear) begin
         r_cnt    <= '0;
         r_active <= 1'b0;
      end else if (r_cnt != '0) begin
         r_cnt    <= r_cnt - W'(1);
         r_active <= (r_cnt > W'(1));
      end else begin
         r_active <= 1'b0;
      end
   end

   assign active = r_active;

endmodule

// File: rtl/uart_key_hold_decoder.sv
// Player 2 keyboard decoder: pops bytes from the UART RX FIFO and turns them into
// held left/right levels and a rate-limited shoot pulse for draw_ship.
module uart_key_hold_decoder
   import warblade_pkg::*;
#(
   parameter int         HOLD_CYCLES     = 4_333_333,
   parameter int         COOLDOWN_CYCLES = 19_500_000,
   parameter logic [7:0] KEY_LEFT        = KEY_LEFT_DEF,
   parameter logic [7:0] KEY_RIGHT       = KEY_RIGHT_DEF,
   parameter logic [7:0] KEY_SHOOT       = KEY_SHOOT_DEF,
   parameter logic [7:0] KEY_STOP        = KEY_STOP_DEF
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       rx_empty,
   input  logic [7:0] r_data,
   output logic       rd_uart,
   output logic       left,
   output logic       right,
   output logic       shoot,
   output logic [7:0] last_key
);

   state_t     r_state;
   state_t     w_next_state;
   logic [7:0] r_byte_q;
   logic [7:0] r_last_key;
   logic       r_shoot;

   logic w_pop;
   logic w_load_left;
   logic w_load_right;
   logic w_clear_left;
   logic w_clear_right;
   logic w_fire;
   logic w_left_active;
   logic w_right_active;
   logic w_cd_active;

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // The settle cycle gives the FIFO one clock to present its next head byte.
   always_comb begin
      w_next_state  = r_state;
      w_pop         = 1'b0;
      w_load_left   = 1'b0;
      w_load_right  = 1'b0;
      w_clear_left  = 1'b0;
      w_clear_right = 1'b0;
      w_fire        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!rx_empty) begin
               w_next_state = S_POP;
            end
         end
         S_POP: begin
            w_pop        = 1'b1;
            w_next_state = S_SETTLE;
            case (r_byte_q)
               KEY_LEFT: begin
                  w_load_left   = 1'b1;
                  w_clear_right = 1'b1;
               end
               KEY_RIGHT: begin
                  w_load_right  = 1'b1;
                  w_clear_left  = 1'b1;
               end
               KEY_STOP: begin
                  w_clear_left  = 1'b1;
                  w_clear_right = 1'b1;
               end
               KEY_SHOOT: begin
                  w_fire = !w_cd_active;
               end
               default: ;
            endcase
         end
         S_SETTLE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (r_state == S_IDLE && !rx_empty) begin
         r_byte_q <= r_data;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_shoot    <= 1'b0;
         r_last_key <= 8'h00;
      end else begin
         r_shoot <= w_fire;
         if (w_pop) begin
            r_last_key <= r_byte_q;
         end
      end
   end

   hold_timer #(.MAX(HOLD_CYCLES)) u_left_tmr (
      .pclk   (pclk),
      .rst    (rst),
      .load   (w_load_left),
      .clear  (w_clear_left),
      .active (w_left_active)
   );

   hold_timer #(.MAX(HOLD_CYCLES)) u_right_tmr (
      .pclk   (pclk),
      .rst    (rst),
      .load   (w_load_right),
      .clear  (w_clear_right),
      .active (w_right_active)
   );

   hold_timer #(.MAX(COOLDOWN_CYCLES)) u_cd_tmr (
      .pclk   (pclk),
      .rst    (rst),
      .load   (w_fire),
      .clear  (1'b0),
      .active (w_cd_active)
   );

   assign rd_uart  = (r_state == S_POP);
   assign left     = w_left_active;
   assign right    = w_right_active;
   assign shoot    = r_shoot;
   assign last_key = r_last_key;

endmodule
